codec_config_sequencer: RTL
===========================

Name: codec_config_sequencer

Overview:
Upstream feeder for the I2C bit engine. After reset or a start pulse, it walks a fixed table of codec register writes. For each entry it drives device_address, reg_address and data_in, holds the request until the engine pulses WE, then advances. It reports done, error and progress to the synthesizer top level.

Parameters:
DEV_ADDR, 8'h34, 8-bit I2C address byte (7-bit address plus R/W=0) placed on device_address[7:0].
NUM_ENTRIES, 8, number of table entries (1..16).
PWRUP_CYCLES, 16'd50000, wait after reset before the first transaction.
GAP_CYCLES, 10'd200, idle cycles between transactions (go low).
TIMEOUT_CYCLES, 16'd20000, maximum cycles from issue to WE before declaring error.
MAX_RETRIES, 2, extra attempts per entry on ACK failure (RETRY_EN only).

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; restarts the table from entry 0 when idle, done or error
i2c_status  in  2  from engine; [0]=transaction in progress, [1]=ACK failed
WE  in  1  one-cycle end-of-transaction pulse from engine (end of stop bit)
device_address  out  9  [8]=go request, [7:0]=DEV_ADDR
reg_address  out  8  register byte of the current entry
data_in  out  8  data byte of the current entry
busy  out  1  high from PWRUP through the last entry
done  out  1  sticky high after all entries succeed
error  out  1  sticky high on NACK (retries exhausted) or timeout
index  out  4  current entry number

Behaviour:
- Reset (async) values: state=PWRUP; device_address=9'h034 with go=0; reg_address=0; data_in=0; busy=1; done=0; error=0; index=0; all counters=0.
- Table: combinational ROM of {reg,data} indexed by index. Contents: 0:{0F,00} 1:{06,10} 2:{00,17} 3:{02,79} 4:{04,12} 5:{05,00} 6:{07,02} 7:{09,01}. Entries at or beyond NUM_ENTRIES are unused.
- States:
  - PWRUP: count to PWRUP_CYCLES-1, then go to LOAD.
  - LOAD: latch the ROM entry into reg_address/data_in (one cycle), then go to ISSUE.
  - ISSUE: go=1; timeout counter clears on entry and increments each cycle.
    - WE=1 with i2c_status[1]=0: go=0, go to GAP.
    - WE=1 with i2c_status[1]=1: go to FAIL.
    - Timeout counter reaching TIMEOUT_CYCLES with no WE: go to ERROR.
  - GAP: go=0 for GAP_CYCLES cycles. Then, if index==NUM_ENTRIES-1, go to DONE; otherwise index+1 and go to LOAD.
  - FAIL: see the optional feature. Default is to go to ERROR.
  - DONE: busy=0, done=1. Wait for start.
  - ERROR: busy=0, error=1, go=0. Index holds the failing entry. Wait for start.
- start in DONE or ERROR: clear done, error, index and the retry counter, set busy=1, go to LOAD. PWRUP is not repeated.
- start in any other state is ignored.
- reg_address and data_in are stable for the whole time go=1. They change only in LOAD.
- go drops in the cycle after WE, so the engine's next get_state sees go=0 and stays idle.
- WE is honoured only in ISSUE. A WE in any other state is ignored.
- A WE in the same cycle as the timeout compare counts as success or fail per i2c_status[1]; WE has priority over timeout.
- Counters saturate and do not wrap. index never exceeds NUM_ENTRIES-1.

Optional Feature:
- Macro: CODEC_CFG_RETRY_EN.
- Defined:
  - FAIL increments the retry counter (clears on LOAD of a new entry). It holds go=0 for GAP_CYCLES, then returns to ISSUE with the same index.
  - The transition to ERROR happens when the retry counter already equals MAX_RETRIES on entry to FAIL.
- Undefined: FAIL goes directly to ERROR on the next cycle. No retry counter is synthesised.

Test Plan:
- Reset, then an engine model that ACKs everything:
  - After PWRUP_CYCLES, 8 transactions occur, reg/data matching the table in order; device_address=9'h134 during each.
  - done=1 and busy=0 after the 8th WE plus GAP_CYCLES; go low ≥GAP_CYCLES between transactions.
- NACK on entry 3 with retries off: error=1, index=3, go=0, done=0; no further WE requests.
- CODEC_CFG_RETRY_EN, NACK on entry 2 twice then ACK: three attempts on index 2, then continue to done=1.
- CODEC_CFG_RETRY_EN, NACK on entry 2 always: exactly 1+MAX_RETRIES=3 attempts, then error=1.
- Engine never pulses WE on entry 0: error=1 exactly TIMEOUT_CYCLES after go rises.
- start pulse in DONE: reruns from index 0 without PWRUP. Reset asserted mid-transaction (index 5): outputs take reset values immediately and go drops asynchronously.

Source files
------------

// File: rtl/codec_config_sequencer.sv
// rtl/codec_config_sequencer.sv - walks a fixed codec register-write table into the I2C bit engine.
// Optional ACK-failure retry is enabled by defining CODEC_CFG_RETRY_EN.
module codec_config_sequencer #(
    parameter logic [7:0]  DEV_ADDR       = 8'h34,
    parameter int          NUM_ENTRIES    = 8,
    parameter logic [15:0] PWRUP_CYCLES   = 16'd50000,
    parameter logic [9:0]  GAP_CYCLES     = 10'd200,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd20000
`ifdef CODEC_CFG_RETRY_EN
    ,
    parameter int          MAX_RETRIES    = 2
`endif
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] i2c_status,
    input  logic       WE,
    output logic [8:0] device_address,
    output logic [7:0] reg_address,
    output logic [7:0] data_in,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [3:0] index
);

    typedef enum logic [2:0] {
        S_PWRUP,
        S_LOAD,
        S_ISSUE,
        S_GAP,
        S_FAIL,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [3:0]  LAST_IDX = 4'(NUM_ENTRIES - 1);
    localparam logic [15:0] GAP_LAST = {6'd0, GAP_CYCLES - 10'd1};
    localparam logic [15:0] PWR_LAST = PWRUP_CYCLES - 16'd1;
    localparam logic [15:0] TMO_LAST = TIMEOUT_CYCLES - 16'd1;

    state_t      state;
    state_t      state_next;
    logic [15:0] cnt;
    logic [15:0] cnt_inc;
    logic        load_entry;
    logic        advance;
    logic        restart;
    logic [7:0]  rom_reg;
    logic [7:0]  rom_data;
    logic        go;
    logic        unused_status;

`ifdef CODEC_CFG_RETRY_EN
    localparam logic [3:0] MAX_R = 4'(MAX_RETRIES);
    logic [3:0] retry_cnt;
    logic       retry_inc;
`endif

    // The engine's in-progress flag is not needed; WE alone closes a transaction.
    assign unused_status = i2c_status[0];

    always_comb begin
        rom_reg  = 8'h00;
        rom_data = 8'h00;
        case (index)
            4'd0: begin rom_reg = 8'h0F; rom_data = 8'h00; end
            4'd1: begin rom_reg = 8'h06; rom_data = 8'h10; end
            4'd2: begin rom_reg = 8'h00; rom_data = 8'h17; end
            4'd3: begin rom_reg = 8'h02; rom_data = 8'h79; end
            4'd4: begin rom_reg = 8'h04; rom_data = 8'h12; end
            4'd5: begin rom_reg = 8'h05; rom_data = 8'h00; end
            4'd6: begin rom_reg = 8'h07; rom_data = 8'h02; end
            4'd7: begin rom_reg = 8'h09; rom_data = 8'h01; end
            default: begin rom_reg = 8'h00; rom_data = 8'h00; end
        endcase
    end

    assign cnt_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;

    always_comb begin
        state_next = state;
        load_entry = 1'b0;
        advance    = 1'b0;
        restart    = 1'b0;
`ifdef CODEC_CFG_RETRY_EN
        retry_inc  = 1'b0;
`endif
        case (state)
            S_PWRUP: if (cnt >= PWR_LAST) state_next = S_LOAD;
            S_LOAD: begin
                load_entry = 1'b1;
                state_next = S_ISSUE;
            end
            S_ISSUE: begin
                // WE wins over a timeout landing in the same cycle.
                if (WE)
                    state_next = i2c_status[1] ? S_FAIL : S_GAP;
                else if (cnt >= TMO_LAST)
                    state_next = S_ERROR;
            end
            S_GAP: begin
                if (cnt >= GAP_LAST) begin
                    if (index == LAST_IDX) begin
                        state_next = S_DONE;
                    end else begin
                        advance    = 1'b1;
                        state_next = S_LOAD;
                    end
                end
            end
            S_FAIL: begin
`ifdef CODEC_CFG_RETRY_EN
                if (retry_cnt >= MAX_R) begin
                    state_next = S_ERROR;
                end else if (cnt >= GAP_LAST) begin
                    retry_inc  = 1'b1;
                    state_next = S_ISSUE;
                end
`else
                state_next = S_ERROR;
`endif
            end
            S_DONE, S_ERROR: begin
                if (start) begin
                    restart    = 1'b1;
                    state_next = S_LOAD;
                end
            end
            default: state_next = S_ERROR;
        endcase
    end

    // The shared counter restarts on every state change, so each state times itself from zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= S_PWRUP;
            cnt         <= 16'd0;
            index       <= 4'd0;
            reg_address <= 8'h00;
            data_in     <= 8'h00;
        end else begin
            state <= state_next;
            cnt   <= (state_next != state) ? 16'd0 : cnt_inc;
            if (load_entry) begin
                reg_address <= rom_reg;
                data_in     <= rom_data;
            end
            if (restart)
                index <= 4'd0;
            else if (advance && index < LAST_IDX)
                index <= index + 4'd1;
        end
    end

`ifdef CODEC_CFG_RETRY_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            retry_cnt <= 4'd0;
        else if (restart || load_entry)
            retry_cnt <= 4'd0;
        else if (retry_inc && retry_cnt != 4'hF)
            retry_cnt <= retry_cnt + 4'd1;
    end
`endif

    // Outputs decode straight from state so go falls asynchronously with reset.
    assign go             = (state == S_ISSUE);
    assign device_address = {go, DEV_ADDR};
    assign busy           = (state != S_DONE) && (state != S_ERROR);
    assign done           = (state == S_DONE);
    assign error          = (state == S_ERROR);

endmodule
